// File: rtl/reg_shift_en.sv
// reg_shift_en: parametrised register with enable, parallel load, single-step
// shift and a counted burst shift driven by a two-state FSM.
// Optional feature macro: SHIFT_ROTATE_EN adds the rot port (rotate instead
// of filling the vacated bit from sin).
module reg_shift_en #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
`ifdef SHIFT_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [CNT_W-1:0] W_CNT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic             r_sout, w_sout_nxt;
    logic [CNT_W-1:0] r_rem, w_rem_nxt;
    logic             r_dir, w_dir_nxt;
    logic             r_done, w_done_nxt;

    logic             w_rot;
    logic             w_use_dir;
    logic [WIDTH-1:0] w_shl, w_shr, w_sh_q;
    logic             w_sh_out;
    logic [CNT_W-1:0] w_n;

`ifdef SHIFT_ROTATE_EN
    assign w_rot = rot;
`else
    assign w_rot = 1'b0;
`endif

    // Shift direction: latched during a burst, otherwise taken from mode[0]
    // (0 = left, 1 = right). The vacated bit is sin, or the outgoing bit
    // when rotating.
    assign w_use_dir = (r_state == BURST) ? r_dir : mode[0];
    assign w_shl     = {r_q[WIDTH-2:0], (w_rot ? r_q[WIDTH-1] : sin)};
    assign w_shr     = {(w_rot ? r_q[0] : sin), r_q[WIDTH-1:1]};
    assign w_sh_q    = w_use_dir ? w_shr : w_shl;
    assign w_sh_out  = w_use_dir ? r_q[0] : r_q[WIDTH-1];

    // Burst length clamped to the register width.
    assign w_n = (count > W_CNT) ? W_CNT : count;

    // Next-state and datapath decode; everything holds unless enabled.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_sout_nxt  = r_sout;
        w_rem_nxt   = r_rem;
        w_dir_nxt   = r_dir;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    if (start && mode[1]) begin
                        w_dir_nxt = mode[0];
                        if (w_n == '0) begin
                            // Zero-length burst: just signal completion.
                            w_done_nxt = 1'b1;
                        end else begin
                            // First shift happens on the start edge itself.
                            w_q_nxt    = w_sh_q;
                            w_sout_nxt = w_sh_out;
                            if (w_n == ONE) begin
                                w_done_nxt = 1'b1;
                            end else begin
                                w_rem_nxt   = w_n - ONE;
                                w_state_nxt = BURST;
                            end
                        end
                    end else begin
                        case (mode)
                            2'b01:   w_q_nxt = d;
                            2'b10,
                            2'b11: begin
                                w_q_nxt    = w_sh_q;
                                w_sout_nxt = w_sh_out;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            BURST: begin
                if (en) begin
                    w_q_nxt    = w_sh_q;
                    w_sout_nxt = w_sh_out;
                    w_rem_nxt  = r_rem - ONE;
                    if (r_rem == ONE) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; synchronous reset aborts any burst
    // without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_q     <= RST_VAL;
            r_sout  <= 1'b0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_sout  <= w_sout_nxt;
            r_rem   <= w_rem_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign q     = r_q;
    assign q_bar = ~r_q;
    assign sout  = r_sout;
    assign busy  = (r_state == BURST);
    assign done  = r_done;

endmodule

// File: tb/tb_reg_shift_en.sv
// tb_reg_shift_en: table-driven bench for reg_shift_en (WIDTH=8), with a
// scoreboard queue of expected post-edge values and hand sequences for
// stalled bursts and (when SHIFT_ROTATE_EN is defined) rotation.
module tb_reg_shift_en;

    logic       clk = 1'b0;
    logic       rst_n, en, sin, start, rot;
    logic [1:0] mode;
    logic [7:0] d;
    logic [3:0] count;
    logic [7:0] q, q_bar;
    logic       sout, busy, done;

    reg_shift_en #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .d     (d),
        .sin   (sin),
        .start (start),
        .count (count),
`ifdef SHIFT_ROTATE_EN
        .rot   (rot),
`endif
        .q     (q),
        .q_bar (q_bar),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n, en;
        logic [1:0] mode;
        logic [7:0] d;
        logic       sin, start;
        logic [3:0] count;
        logic [7:0] eq;
        logic       es, eb, ed;
    } vec_t;

    typedef struct packed {
        logic [7:0] q;
        logic       s, b, dn;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    endtask

    // Push the expectation, clock once, then pop and compare away from the edge.
    task automatic step(input int idx, input logic [7:0] eq, input logic es, input logic eb, input logic ed);
        exp_t e;
        sb.push_back('{q: eq, s: es, b: eb, dn: ed});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard step %0d: queue empty", idx);
        end else begin
            e = sb.pop_front();
            chk("q",     idx, q,            e.q);
            chk("q_bar", idx, q_bar,        ~e.q);
            chk("sout",  idx, {7'd0, sout}, {7'd0, e.s});
            chk("busy",  idx, {7'd0, busy}, {7'd0, e.b});
            chk("done",  idx, {7'd0, done}, {7'd0, e.dn});
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m, input logic [7:0] dd,
                         input logic s, input logic st, input logic [3:0] c);
        rst_n = r; en = e; mode = m; d = dd; sin = s; start = st; count = c;
    endtask

    vec_t tv[35];
`ifdef SHIFT_ROTATE_EN
    logic [7:0] rq[8];
    logic       rs[8];
`endif

    initial begin
        rot = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 8'h00, 1'b0, 1'b0, 4'd0);

        //         rst  en  mode   d      sin   start count  q      sout  busy  done
        tv[0]  = '{1'b0,1'b1,2'b01,8'hFF,1'b0,1'b0,4'd0, 8'h00,1'b0,1'b0,1'b0}; // reset beats load
        tv[1]  = '{1'b1,1'b1,2'b01,8'hA5,1'b0,1'b0,4'd0, 8'hA5,1'b0,1'b0,1'b0}; // load
        tv[2]  = '{1'b1,1'b1,2'b10,8'h00,1'b1,1'b0,4'd0, 8'h4B,1'b1,1'b0,1'b0}; // shl sin=1
        tv[3]  = '{1'b1,1'b1,2'b11,8'h00,1'b0,1'b0,4'd0, 8'h25,1'b1,1'b0,1'b0}; // shr sin=0
        tv[4]  = '{1'b1,1'b0,2'b01,8'h00,1'b0,1'b0,4'd0, 8'h25,1'b1,1'b0,1'b0}; // en=0 holds
        tv[5]  = '{1'b1,1'b1,2'b00,8'h00,1'b0,1'b0,4'd0, 8'h25,1'b1,1'b0,1'b0}; // mode hold
        tv[6]  = '{1'b1,1'b1,2'b01,8'h81,1'b0,1'b1,4'd3, 8'h81,1'b1,1'b0,1'b0}; // start w/ load ignored
        tv[7]  = '{1'b1,1'b0,2'b10,8'h00,1'b0,1'b1,4'd3, 8'h81,1'b1,1'b0,1'b0}; // start w/ en=0 ignored
        tv[8]  = '{1'b1,1'b1,2'b11,8'h00,1'b0,1'b1,4'd3, 8'h40,1'b1,1'b1,1'b0}; // burst r x3, shift 1
        tv[9]  = '{1'b1,1'b1,2'b01,8'hFF,1'b0,1'b0,4'd0, 8'h20,1'b0,1'b1,1'b0}; // d ignored in burst
        tv[10] = '{1'b1,1'b1,2'b00,8'h00,1'b0,1'b1,4'd0, 8'h10,1'b0,1'b0,1'b1}; // shift 3, done
        tv[11] = '{1'b1,1'b1,2'b00,8'h00,1'b0,1'b0,4'd0, 8'h10,1'b0,1'b0,1'b0}; // done one cycle
        tv[12] = '{1'b1,1'b1,2'b10,8'h00,1'b1,1'b1,4'd4, 8'h21,1'b0,1'b1,1'b0}; // burst l x4
        tv[13] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h43,1'b0,1'b1,1'b0};
        tv[14] = '{1'b1,1'b0,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h43,1'b0,1'b1,1'b0}; // stall
        tv[15] = '{1'b1,1'b0,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h43,1'b0,1'b1,1'b0}; // stall
        tv[16] = '{1'b1,1'b1,2'b00,8'h00,1'b0,1'b0,4'd0, 8'h86,1'b0,1'b1,1'b0};
        tv[17] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h0D,1'b1,1'b0,1'b1}; // 4th shift, done
        tv[18] = '{1'b1,1'b1,2'b10,8'h00,1'b1,1'b1,4'd0, 8'h0D,1'b1,1'b0,1'b1}; // count=0
        tv[19] = '{1'b1,1'b1,2'b00,8'h00,1'b0,1'b0,4'd0, 8'h0D,1'b1,1'b0,1'b0};
        tv[20] = '{1'b1,1'b1,2'b11,8'h00,1'b1,1'b1,4'd1, 8'h86,1'b1,1'b0,1'b1}; // count=1
        tv[21] = '{1'b1,1'b1,2'b10,8'h00,1'b1,1'b1,4'd15,8'h0D,1'b1,1'b1,1'b0}; // count clamps to 8
        tv[22] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h1B,1'b0,1'b1,1'b0};
        tv[23] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h37,1'b0,1'b1,1'b0};
        tv[24] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h6F,1'b0,1'b1,1'b0};
        tv[25] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'hDF,1'b0,1'b1,1'b0};
        tv[26] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'hBF,1'b1,1'b1,1'b0};
        tv[27] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'h7F,1'b1,1'b1,1'b0};
        tv[28] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'hFF,1'b0,1'b0,1'b1}; // 8th shift
        tv[29] = '{1'b1,1'b1,2'b00,8'h00,1'b1,1'b0,4'd0, 8'hFF,1'b0,1'b0,1'b0};
        tv[30] = '{1'b1,1'b1,2'b11,8'h00,1'b0,1'b1,4'd4, 8'h7F,1'b1,1'b1,1'b0}; // burst r x4
        tv[31] = '{1'b1,1'b1,2'b00,8'h00,1'b0,1'b0,4'd0, 8'h3F,1'b1,1'b1,1'b0}; // remaining=2
        tv[32] = '{1'b0,1'b1,2'b00,8'h00,1'b0,1'b0,4'd0, 8'h00,1'b0,1'b0,1'b0}; // reset aborts
        tv[33] = '{1'b1,1'b1,2'b00,8'h00,1'b0,1'b0,4'd0, 8'h00,1'b0,1'b0,1'b0}; // no late done
        tv[34] = '{1'b1,1'b1,2'b11,8'h00,1'b1,1'b0,4'd0, 8'h80,1'b0,1'b0,1'b0}; // back in IDLE

        #1;
        for (int i = 0; i < 35; i++) begin
            drive(tv[i].rst_n, tv[i].en, tv[i].mode, tv[i].d, tv[i].sin, tv[i].start, tv[i].count);
            step(i, tv[i].eq, tv[i].es, tv[i].eb, tv[i].ed);
        end

        // Burst of 2 with a stall straight after the start edge.
        drive(1'b1, 1'b1, 2'b01, 8'h5A, 1'b0, 1'b0, 4'd0); step(100, 8'h5A, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 4'd2); step(101, 8'hB4, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 2'b11, 8'h00, 1'b1, 1'b1, 4'd7); step(102, 8'hB4, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 2'b11, 8'h00, 1'b0, 1'b0, 4'd0); step(103, 8'h68, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 4'd0); step(104, 8'h68, 1'b1, 1'b0, 1'b0);

`ifdef SHIFT_ROTATE_EN
        // Rotate left: single step, then a clamped 15-count burst returns to start.
        drive(1'b1, 1'b1, 2'b01, 8'h81, 1'b0, 1'b0, 4'd0); step(200, 8'h81, 1'b1, 1'b0, 1'b0);
        rot = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0, 4'd0); step(201, 8'h03, 1'b1, 1'b0, 1'b0);
        rot = 1'b0;
        drive(1'b1, 1'b1, 2'b01, 8'h81, 1'b0, 1'b0, 4'd0); step(202, 8'h81, 1'b1, 1'b0, 1'b0);
        rq = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        rs = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        rot = 1'b1;
        drive(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1, 4'd15);
        for (int k = 0; k < 8; k++) begin
            step(210 + k, rq[k], rs[k], (k < 7), (k == 7));
            drive(1'b1, 1'b1, 2'b00, 8'h00, 1'b0, 1'b0, 4'd0);
        end
        rot = 1'b0;
        step(218, 8'h81, 1'b1, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
